mem_stage_ctrl: RTL and testbench

Memory-stage controller for the NN CPU pipeline. It consumes the execute-stage outputs (MemRead, MemWrite, RegWrite, MemtoReg, ALU result, store data, destination register) and acts as the responder that carries out data-memory accesses over a req/ack interface. While an access is in flight it stalls the upstream pipeline registers. Each completed instruction, or a bubble, is registered into the writeback stage.

---
 rtl/nn_cpu_pkg.sv | 22 ++
 rtl/mem_timeout_ctr.sv | 46 ++++
 rtl/mem_stage_ctrl.sv | 150 +++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_cpu_pkg.sv
// ============================================================================
// Module   : nn_cpu_pkg
// Purpose  : Shared types and default widths for the NN CPU memory stage.
// Contents : mem_state_t - memory-stage controller state (IDLE / ACCESS)
//            BUS_WIDTH_DEF, REGISTER_SIZE_DEF - default datapath widths
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package nn_cpu_pkg;

  localparam int BUS_WIDTH_DEF     = 32;
  localparam int REGISTER_SIZE_DEF = 6;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

endpackage

`default_nettype wire

// File: rtl/mem_timeout_ctr.sv
// ============================================================================
// Module   : mem_timeout_ctr
// Purpose  : Clear/enable cycle counter for the memory access watchdog.
// Ports    : clk    - clock, rising edge
//            rst_n  - asynchronous active-low reset
//            i_clr  - synchronous clear (priority over enable)
//            i_en   - count enable
//            o_tc   - terminal count: the counter holds TIMEOUT_CYCLES-1,
//                     so one more unacknowledged cycle exhausts the budget
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int              CW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]   C_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0]   C_ONE  = CW'(1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + C_ONE;
    end
  end

  // Flags the cycle that would be the TIMEOUT_CYCLES-th without an ack, so
  // the owner can abort at the end of that same cycle.
  assign o_tc = (r_count == C_LAST);

endmodule

`default_nettype wire

// File: rtl/mem_stage_ctrl.sv
// ============================================================================
// Module   : mem_stage_ctrl
// Purpose  : Memory-stage controller. Issues data-memory accesses over a
//            req/ack interface, stalls upstream while an access is pending,
//            and registers each completed instruction (or a bubble) into WB.
// Ports    : CLK, RST_N                       - clock / async active-low reset
//            RegWriteE, MemtoRegE, MemReadE,
//            MemWriteE, ALUOutE, WriteDataE,
//            WriteRegE                        - execute-stage inputs
//            StallM                           - combinational upstream stall
//            MemReq, MemWe, MemAddr, MemWData - registered memory request
//            MemAck, MemRData                 - memory completion / load data
//            RegWriteW, MemtoRegW, WriteRegW,
//            ALUOutW, ReadDataW               - writeback pipeline register
//            MemErr                           - one-cycle timeout abort pulse
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage_ctrl
  import nn_cpu_pkg::*;
#(
  parameter int BUS_WIDTH      = BUS_WIDTH_DEF,
  parameter int REGISTER_SIZE  = REGISTER_SIZE_DEF,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     RegWriteE,
  input  logic                     MemtoRegE,
  input  logic                     MemReadE,
  input  logic                     MemWriteE,
  input  logic [BUS_WIDTH-1:0]     ALUOutE,
  input  logic [BUS_WIDTH-1:0]     WriteDataE,
  input  logic [REGISTER_SIZE-1:0] WriteRegE,
  output logic                     StallM,
  output logic                     MemReq,
  output logic                     MemWe,
  output logic [BUS_WIDTH-1:0]     MemAddr,
  output logic [BUS_WIDTH-1:0]     MemWData,
  input  logic                     MemAck,
  input  logic [BUS_WIDTH-1:0]     MemRData,
  output logic                     RegWriteW,
  output logic                     MemtoRegW,
  output logic [REGISTER_SIZE-1:0] WriteRegW,
  output logic [BUS_WIDTH-1:0]     ALUOutW,
  output logic [BUS_WIDTH-1:0]     ReadDataW,
  output logic                     MemErr
);

  mem_state_t               r_state;
  logic                     r_lat_rw;
  logic                     r_lat_m2r;
  logic                     r_lat_load;
  logic [REGISTER_SIZE-1:0] r_lat_wreg;

  logic w_memop;
  logic w_in_access;
  logic w_done;
  logic w_tc;
  logic w_abort;

  assign w_memop     = MemReadE | MemWriteE;
  assign w_in_access = (r_state == ACCESS);
  assign w_done      = w_in_access & MemAck;
  // An ack arriving in the last allowed cycle still completes normally.
  assign w_abort     = w_in_access & ~MemAck & w_tc;

  // Gated by RST_N so every output reads 0 while reset is held, even with a
  // memory op sitting on the E inputs.
  assign StallM = RST_N & (w_in_access ? (~MemAck & ~w_tc) : w_memop);

  mem_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (CLK),
    .rst_n (RST_N),
    .i_clr (~w_in_access | MemAck),
    .i_en  (w_in_access & ~MemAck),
    .o_tc  (w_tc)
  );

  // State, request latch and error pulse.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= IDLE;
      MemReq     <= 1'b0;
      MemWe      <= 1'b0;
      MemAddr    <= '0;
      MemWData   <= '0;
      MemErr     <= 1'b0;
      r_lat_rw   <= 1'b0;
      r_lat_m2r  <= 1'b0;
      r_lat_load <= 1'b0;
      r_lat_wreg <= '0;
    end else begin
      MemErr <= w_abort;
      if (!w_in_access) begin
        if (w_memop) begin
          r_state    <= ACCESS;
          MemReq     <= 1'b1;
          MemWe      <= MemWriteE;
          MemAddr    <= ALUOutE;
          MemWData   <= WriteDataE;
          // Read+write together is a store: it never writes a register.
          r_lat_rw   <= RegWriteE & ~(MemReadE & MemWriteE);
          r_lat_m2r  <= MemtoRegE;
          r_lat_load <= ~MemWriteE;
          r_lat_wreg <= WriteRegE;
        end
      end else if (w_done || w_abort) begin
        r_state <= IDLE;
        MemReq  <= 1'b0;
        MemWe   <= 1'b0;
      end
    end
  end

  // Writeback pipeline register: passthrough, completed access, or bubble.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
      WriteRegW <= '0;
      ALUOutW   <= '0;
      ReadDataW <= '0;
    end else if (!w_in_access && !w_memop) begin
      RegWriteW <= RegWriteE;
      MemtoRegW <= MemtoRegE;
      WriteRegW <= WriteRegE;
      ALUOutW   <= ALUOutE;
      ReadDataW <= '0;
    end else if (w_done) begin
      RegWriteW <= r_lat_rw;
      MemtoRegW <= r_lat_m2r;
      WriteRegW <= r_lat_wreg;
      ALUOutW   <= MemAddr;
      ReadDataW <= r_lat_load ? MemRData : '0;
    end else begin
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
      WriteRegW <= '0;
      ALUOutW   <= '0;
      ReadDataW <= '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
// ============================================================================
// Module   : tb_mem_stage_ctrl
// Purpose  : Self-checking bench for mem_stage_ctrl: directed scenarios with
//            literal expectations, then randomized traffic compared every
//            cycle against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage_ctrl;

  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        RegWriteE = 1'b0, MemtoRegE = 1'b0, MemReadE = 1'b0, MemWriteE = 1'b0;
  logic [31:0] ALUOutE = '0, WriteDataE = '0;
  logic [5:0]  WriteRegE = '0;
  logic        StallM, MemReq, MemWe;
  logic [31:0] MemAddr, MemWData;
  logic        MemAck = 1'b0;
  logic [31:0] MemRData = '0;
  logic        RegWriteW, MemtoRegW;
  logic [5:0]  WriteRegW;
  logic [31:0] ALUOutW, ReadDataW;
  logic        MemErr;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_on   = 1'b0;

  mem_stage_ctrl #(
    .BUS_WIDTH      (32),
    .REGISTER_SIZE  (6),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .RegWriteE  (RegWriteE),
    .MemtoRegE  (MemtoRegE),
    .MemReadE   (MemReadE),
    .MemWriteE  (MemWriteE),
    .ALUOutE    (ALUOutE),
    .WriteDataE (WriteDataE),
    .WriteRegE  (WriteRegE),
    .StallM     (StallM),
    .MemReq     (MemReq),
    .MemWe      (MemWe),
    .MemAddr    (MemAddr),
    .MemWData   (MemWData),
    .MemAck     (MemAck),
    .MemRData   (MemRData),
    .RegWriteW  (RegWriteW),
    .MemtoRegW  (MemtoRegW),
    .WriteRegW  (WriteRegW),
    .ALUOutW    (ALUOutW),
    .ReadDataW  (ReadDataW),
    .MemErr     (MemErr)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  bit          m_busy = 0;       // an access is outstanding
  int          m_wait = 0;       // unacknowledged access cycles so far
  bit          m_lrw = 0, m_lm2r = 0, m_lload = 0;
  logic [5:0]  m_lwreg = '0;
  bit          m_req = 0, m_we = 0, m_err = 0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  bit          m_rw = 0, m_m2r = 0;
  logic [5:0]  m_wreg = '0;
  logic [31:0] m_alu = '0, m_rd = '0;

  task automatic m_bubble();
    m_rw = 0; m_m2r = 0; m_wreg = '0; m_alu = '0; m_rd = '0;
  endtask

  initial forever begin
    @(posedge CLK or negedge RST_N);
    if (!RST_N) begin
      m_busy = 0; m_wait = 0; m_req = 0; m_we = 0; m_err = 0;
      m_addr = '0; m_wdata = '0;
      m_bubble();
    end else begin
      m_err = 0;
      if (!m_busy) begin
        if (!(MemReadE || MemWriteE)) begin
          m_rw = RegWriteE; m_m2r = MemtoRegE; m_wreg = WriteRegE;
          m_alu = ALUOutE; m_rd = '0;
        end else begin
          m_busy  = 1; m_wait = 0; m_req = 1; m_we = MemWriteE;
          m_addr  = ALUOutE; m_wdata = WriteDataE;
          m_lload = !MemWriteE;
          m_lrw   = RegWriteE && !(MemReadE && MemWriteE);
          m_lm2r  = MemtoRegE; m_lwreg = WriteRegE;
          m_bubble();
        end
      end else if (MemAck) begin
        m_rw = m_lrw; m_m2r = m_lm2r; m_wreg = m_lwreg; m_alu = m_addr;
        m_rd = m_lload ? MemRData : 32'h0;
        m_busy = 0; m_req = 0; m_we = 0;
      end else if (m_wait + 1 == TO) begin
        m_bubble();
        m_err = 1; m_busy = 0; m_req = 0; m_we = 0;
      end else begin
        m_wait++;
        m_bubble();
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge CLK);
    if (cmp_on) begin
      bit exp_stall;
      if (!RST_N)      exp_stall = 0;
      else if (m_busy) exp_stall = !MemAck && (m_wait + 1 != TO);
      else             exp_stall = MemReadE || MemWriteE;
      chk("StallM",    64'(StallM),    64'(exp_stall));
      chk("MemReq",    64'(MemReq),    64'(m_req));
      chk("MemWe",     64'(MemWe),     64'(m_we));
      chk("MemAddr",   64'(MemAddr),   64'(m_addr));
      chk("MemWData",  64'(MemWData),  64'(m_wdata));
      chk("MemErr",    64'(MemErr),    64'(m_err));
      chk("RegWriteW", 64'(RegWriteW), 64'(m_rw));
      chk("MemtoRegW", 64'(MemtoRegW), 64'(m_m2r));
      chk("WriteRegW", 64'(WriteRegW), 64'(m_wreg));
      chk("ALUOutW",   64'(ALUOutW),   64'(m_alu));
      chk("ReadDataW", 64'(ReadDataW), 64'(m_rd));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_nop();
    RegWriteE = 0; MemtoRegE = 0; MemReadE = 0; MemWriteE = 0;
    ALUOutE = '0; WriteDataE = '0; WriteRegE = '0;
  endtask

  task automatic set_load(input logic [31:0] addr, input logic [5:0] rd);
    set_nop();
    MemReadE = 1; MemtoRegE = 1; RegWriteE = 1; ALUOutE = addr; WriteRegE = rd;
  endtask

  initial begin
    // Reset held from time 0: all outputs must be zero.
    step();
    chk("rst_memreq", 64'(MemReq), 64'h0);
    chk("rst_stall",  64'(StallM), 64'h0);
    chk("rst_rw",     64'(RegWriteW), 64'h0);
    chk("rst_err",    64'(MemErr), 64'h0);
    RST_N  = 1;
    cmp_on = 1;

    // ALU passthrough.
    step();
    RegWriteE = 1; ALUOutE = 32'h10; WriteRegE = 6'd5;
    #1 chk("pt_stall", 64'(StallM), 64'h0);
    step();
    chk("pt_rw",   64'(RegWriteW), 64'h1);
    chk("pt_alu",  64'(ALUOutW),   64'h10);
    chk("pt_wreg", 64'(WriteRegW), 64'h5);

    // Load acknowledged in the 3rd ACCESS cycle.
    set_load(32'h40, 6'd7);
    #1 chk("ld_stall_det", 64'(StallM), 64'h1);
    chk("ld_req_det", 64'(MemReq), 64'h0);
    step(); set_nop();
    #1 chk("ld_req1", 64'(MemReq), 64'h1);
    chk("ld_addr", 64'(MemAddr), 64'h40);
    chk("ld_we",   64'(MemWe), 64'h0);
    chk("ld_stall1", 64'(StallM), 64'h1);
    step();
    #1 chk("ld_req2", 64'(MemReq), 64'h1);
    chk("ld_stall2", 64'(StallM), 64'h1);
    step();
    MemAck = 1; MemRData = 32'hDEADBEEF;
    #1 chk("ld_req3", 64'(MemReq), 64'h1);
    chk("ld_stall3", 64'(StallM), 64'h0);
    step(); MemAck = 0;
    #1 chk("ld_rw", 64'(RegWriteW), 64'h1);
    chk("ld_m2r",  64'(MemtoRegW), 64'h1);
    chk("ld_data", 64'(ReadDataW), 64'hDEADBEEF);
    chk("ld_wreg", 64'(WriteRegW), 64'h7);
    chk("ld_req_off", 64'(MemReq), 64'h0);

    // Store with immediate ack.
    set_nop(); MemWriteE = 1; ALUOutE = 32'h80; WriteDataE = 32'h1234;
    #1 chk("st_stall_det", 64'(StallM), 64'h1);
    step(); set_nop(); MemAck = 1;
    #1 chk("st_req",   64'(MemReq), 64'h1);
    chk("st_we",    64'(MemWe), 64'h1);
    chk("st_addr",  64'(MemAddr), 64'h80);
    chk("st_wdata", 64'(MemWData), 64'h1234);
    chk("st_stall", 64'(StallM), 64'h0);
    step(); MemAck = 0;
    #1 chk("st_rw", 64'(RegWriteW), 64'h0);
    chk("st_rd",  64'(ReadDataW), 64'h0);
    chk("st_req_off", 64'(MemReq), 64'h0);
    chk("st_we_off",  64'(MemWe), 64'h0);

    // Timeout: no ack, TO=4 cycles of MemReq, then a one-cycle MemErr.
    set_load(32'h44, 6'd9);
    step(); set_nop();
    for (int i = 1; i <= TO; i++) begin
      #1 chk("to_req", 64'(MemReq), 64'h1);
      chk("to_stall", 64'(StallM), (i < TO) ? 64'h1 : 64'h0);
      step();
    end
    #1 chk("to_err", 64'(MemErr), 64'h1);
    chk("to_rw",  64'(RegWriteW), 64'h0);
    chk("to_rd",  64'(ReadDataW), 64'h0);
    chk("to_req_off", 64'(MemReq), 64'h0);
    step();
    #1 chk("to_err_off", 64'(MemErr), 64'h0);

    // Reset in the middle of an access, then a fresh load.
    set_load(32'h48, 6'd3);
    step(); set_nop();
    #1 chk("ra_req", 64'(MemReq), 64'h1);
    #1 RST_N = 0;
    #1 chk("ra_req_async", 64'(MemReq), 64'h0);
    chk("ra_stall", 64'(StallM), 64'h0);
    chk("ra_rw",    64'(RegWriteW), 64'h0);
    @(negedge CLK); #1 RST_N = 1;
    step();
    #1 chk("ra_no_wb", 64'(RegWriteW), 64'h0);
    set_load(32'h4C, 6'd4);
    step(); set_nop(); MemAck = 1; MemRData = 32'hCAFEF00D;
    #1 chk("ra_req2", 64'(MemReq), 64'h1);
    chk("ra_addr", 64'(MemAddr), 64'h4C);
    step(); MemAck = 0;
    #1 chk("ra_data", 64'(ReadDataW), 64'hCAFEF00D);
    chk("ra_rw2", 64'(RegWriteW), 64'h1);

    // Randomized traffic; the compare process checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      int op;
      step();
      op         = int'($urandom_range(0, 9));
      MemReadE   = (op < 3);
      MemWriteE  = (op >= 2 && op < 5);
      RegWriteE  = 1'($urandom);
      MemtoRegE  = 1'($urandom);
      ALUOutE    = $urandom;
      WriteDataE = $urandom;
      WriteRegE  = 6'($urandom);
      MemAck     = ($urandom_range(0, 9) < 3);
      MemRData   = $urandom;
      if ($urandom_range(0, 399) == 0) begin
        #1 RST_N = 0;
        #2 RST_N = 1;
      end
    end

    step();
    cmp_on = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
